mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive dcache grants tolerated while iREN pending before icache is forced.
REQ-002 SHALL have parameter TIMEOUT, default 255: grant cycles without ACCESS before the grant is abandoned (8-bit counter).
REQ-003 CLK  input  1  clock, all state on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 iREN  input  1  icache read request, held until iwait low.
REQ-006 iaddr  input  32  icache word address.
REQ-007 iwait  output  1  low for exactly the completing cycle of an icache access.
REQ-008 iload  output  32  instruction data, valid when iwait low.
REQ-009 dREN / dWEN  input  1 each  dcache read / write request, held until dwait low.
REQ-010 daddr, dstore  input  32 each  dcache address, write data.
REQ-011 dwait  output  1  low for exactly the completing cycle of a dcache access.
REQ-012 dload  output  32  data read result, valid when dwait low after a read.
REQ-013 ramREN, ramWEN  output  1 each  memory port strobes.
REQ-014 ramaddr, ramstore  output  32 each  memory port address, write data.
REQ-015 ramload  input  32  memory read data.
REQ-016 ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-017 err  output  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, IGRANT, DGRANT; state registered.
REQ-019 IDLE: ram strobes 0; next state DGRANT if (dREN|dWEN) and starve count < STARVE_LIMIT, else IGRANT if iREN, else DGRANT if (dREN|dWEN), else IDLE.
REQ-020 Arbitration latency: one cycle; a request first seen in IDLE drives the ram port no earlier than the following cycle.
REQ-021 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0, combinationally from inputs.
REQ-022 DGRANT: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins when both asserted), ramaddr=daddr, ramstore=dstore.
REQ-023 Completion: in a grant state with ramstate==ACCESS, owner wait=0 and owner load=ramload that same cycle; next state IDLE.
REQ-024 Non-owner wait SHALL stay 1; both waits are 1 in IDLE; a wait is never low without its request asserted.
REQ-025 Abort: owner request deasserted while granted -> strobes 0 that cycle, next state IDLE, no wait pulse.
REQ-026 ramstate==ERROR while granted -> err set, wait stays 1, next state IDLE; the request re-arbitrates.
REQ-027 Timeout counter clears on grant entry, increments each grant cycle without ACCESS; at TIMEOUT -> err set, next state IDLE.
REQ-028 Starve counter (width clog2(STARVE_LIMIT+1)): +1 on each dcache completion while iREN high, saturating; cleared on icache completion or whenever iREN low.
REQ-029 iload/dload SHALL hold last completed value when not completing.
REQ-030 err clears only on RST.

Reset
REQ-031 RST high at a rising edge -> state IDLE, counters 0, err 0, iwait=dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0; outputs SHALL reach these values in the cycle after the edge, regardless of state.
REQ-032 RST asserted mid-grant abandons the access with no wait pulse; the first grant after RST release follows the REQ-020 latency.

Verification
REQ-033 iREN=1, iaddr=0x100, ramstate ACCESS on 2nd grant cycle, ramload=0xDEADBEEF -> IGRANT one cycle after request; iwait low one cycle, iload=0xDEADBEEF.
REQ-034 iREN and dWEN high together, daddr=0x200, dstore=0x1234 -> DGRANT first, ramWEN=1, ramstore=0x1234; IGRANT after dwait pulse.
REQ-035 STARVE_LIMIT=3, iREN held, dREN re-asserted after each completion -> exactly 3 dcache grants then IGRANT.
REQ-036 Grant held with ramstate BUSY 255 cycles -> err=1, IDLE, wait never low; same with ramstate=3 -> err=1 next cycle.
REQ-037 dREN dropped in DGRANT before ACCESS -> ramREN 0 same cycle, IDLE next, dwait stays 1, err 0.
REQ-038 RST pulsed during DGRANT -> all outputs at reset values next cycle; pending iREN granted one cycle after RST low.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache/memory bundle seen by the arbiter: icache and dcache request ports plus the single RAM port.
// Requests are held until the matching wait drops, and the arbiter answers in the same cycle once the grant is live.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: dcache priority with icache starvation guard, one-cycle arbitration, grant timeout.
// RAM port and wait/load outputs follow the inputs combinationally while granted; requesters stall on wait.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 255
) (
    input logic           CLK,
    input logic           RST,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t        state_q;
    logic [7:0]    tmo_q;
    logic [SW-1:0] starve_q;
    logic          err_q;
    logic [31:0]   iload_q;
    logic [31:0]   dload_q;

    logic d_req;
    logic i_own;
    logic d_own;
    logic own_req;
    logic i_done;
    logic d_done;

    assign d_req   = bus.dREN | bus.dWEN;
    assign i_own   = (state_q == IGRANT);
    assign d_own   = (state_q == DGRANT);
    assign own_req = (i_own & bus.iREN) | (d_own & d_req);

    // A completion only counts while the owner still holds its request.
    assign i_done = i_own & bus.iREN & (bus.ramstate == RS_ACCESS);
    assign d_done = d_own & d_req & (bus.ramstate == RS_ACCESS);

    assign bus.ramREN   = (i_own & bus.iREN) | (d_own & bus.dREN & ~bus.dWEN);
    assign bus.ramWEN   = d_own & bus.dWEN;
    assign bus.ramaddr  = i_own ? bus.iaddr : (d_own ? bus.daddr : 32'd0);
    assign bus.ramstore = d_own ? bus.dstore : 32'd0;

    assign bus.iwait = ~i_done;
    assign bus.dwait = ~d_done;
    assign bus.iload = i_done ? bus.ramload : iload_q;
    assign bus.dload = d_done ? bus.ramload : dload_q;
    assign bus.err   = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            if (i_done) iload_q <= bus.ramload;
            if (d_done) dload_q <= bus.ramload;

            if (!bus.iREN || i_done) begin
                starve_q <= '0;
            end else if (d_done && starve_q != STARVE_MAX) begin
                starve_q <= starve_q + SW'(1);
            end

            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (d_req && starve_q < STARVE_MAX) begin
                        state_q <= DGRANT;
                    end else if (bus.iREN) begin
                        state_q <= IGRANT;
                    end else if (d_req) begin
                        state_q <= DGRANT;
                    end
                end
                IGRANT, DGRANT: begin
                    // Abort beats error beats completion beats timeout.
                    if (!own_req) begin
                        state_q <= IDLE;
                    end else if (bus.ramstate == RS_ERROR) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (bus.ramstate == RS_ACCESS) begin
                        state_q <= IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(255)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic        is_d;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic push(input logic is_d, input logic chk, input logic [31:0] dat);
        exp_t e;
        e.is_d = is_d;
        e.chk  = chk;
        e.dat  = dat;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_iwait"}, bus.iwait, 1'b1);
        chk1({tag, "_dwait"}, bus.dwait, 1'b1);
        chk32({tag, "_iload"}, bus.iload, 32'd0);
        chk32({tag, "_dload"}, bus.dload, 32'd0);
        chk1({tag, "_ramREN"}, bus.ramREN, 1'b0);
        chk1({tag, "_ramWEN"}, bus.ramWEN, 1'b0);
        chk32({tag, "_ramaddr"}, bus.ramaddr, 32'd0);
        chk32({tag, "_ramstore"}, bus.ramstore, 32'd0);
        chk1({tag, "_err"}, bus.err, 1'b0);
    endtask

    task automatic mon_pop(input logic is_d, input logic [31:0] ld);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_completion: actual=%s wait low required=no completion",
                     is_d ? "dcache" : "icache");
        end else begin
            e = exp_q.pop_front();
            total--;
            chk1("completion_port", is_d, e.is_d);
            if (e.chk) chk32(is_d ? "dload" : "iload", ld, e.dat);
        end
    endtask

    // Scoreboard monitor: every wait-low cycle must match the next expected completion.
    initial begin
        forever begin
            @(negedge CLK);
            if (bus.iwait === 1'b0) mon_pop(1'b0, bus.iload);
            if (bus.dwait === 1'b0) mon_pop(1'b1, bus.dload);
        end
    end

    initial begin
        int n;
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        smp(); chk_reset("rst0");

        // icache read, ACCESS on second grant cycle
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = BUSY; bus.ramload = 32'hDEADBEEF;
        push(1'b0, 1'b1, 32'hDEADBEEF);
        smp(); chk1("t1_idle_ramREN", bus.ramREN, 1'b0);
        tick(); smp();
        chk1("t1_gnt_ramREN", bus.ramREN, 1'b1);
        chk32("t1_gnt_ramaddr", bus.ramaddr, 32'h100);
        chk1("t1_gnt_iwait", bus.iwait, 1'b1);
        tick(); bus.ramstate = ACCESS;
        smp(); chk1("t1_done_iwait", bus.iwait, 1'b0);
        tick(); bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = 32'h0;
        smp();
        chk32("t1_hold_iload", bus.iload, 32'hDEADBEEF);
        chk1("t1_after_ramREN", bus.ramREN, 1'b0);

        // simultaneous iREN and dWEN: dcache first, then icache
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.dWEN = 1'b1; bus.daddr = 32'h200;
        bus.dstore = 32'h1234; bus.ramstate = BUSY;
        push(1'b1, 1'b0, 32'h0);
        push(1'b0, 1'b1, 32'hCAFEF00D);
        smp(); chk1("t2_idle_ramWEN", bus.ramWEN, 1'b0);
        tick(); smp();
        chk1("t2_dgnt_ramWEN", bus.ramWEN, 1'b1);
        chk1("t2_dgnt_ramREN", bus.ramREN, 1'b0);
        chk32("t2_dgnt_ramaddr", bus.ramaddr, 32'h200);
        chk32("t2_dgnt_ramstore", bus.ramstore, 32'h1234);
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h5555;
        smp(); chk1("t2_dwait_low", bus.dwait, 1'b0); chk1("t2_iwait_high", bus.iwait, 1'b1);
        tick(); bus.dWEN = 1'b0; bus.ramstate = BUSY;
        smp(); chk1("t2_idle_ramREN", bus.ramREN, 1'b0);
        tick(); smp();
        chk1("t2_igrant_ramREN", bus.ramREN, 1'b1);
        chk32("t2_igrant_ramaddr", bus.ramaddr, 32'h300);
        chk32("t2_igrant_ramstore", bus.ramstore, 32'h0);
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
        smp();
        tick(); bus.iREN = 1'b0; bus.ramstate = FREE;
        smp(); chk32("t2_hold_iload", bus.iload, 32'hCAFEF00D);

        // starvation: three dcache grants, then icache forced
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h400;
        for (int k = 0; k < 3; k++) begin
            bus.dREN = 1'b1; bus.daddr = 32'h500 + 32'(k); bus.ramstate = BUSY;
            push(1'b1, 1'b1, 32'hA0 + 32'(k));
            smp(); chk1("t3_idle_ramREN", bus.ramREN, 1'b0);
            tick(); smp();
            chk1("t3_dgnt_ramREN", bus.ramREN, 1'b1);
            chk32("t3_dgnt_ramaddr", bus.ramaddr, 32'h500 + 32'(k));
            tick(); bus.ramstate = ACCESS; bus.ramload = 32'hA0 + 32'(k);
            smp();
            tick(); bus.dREN = 1'b0; bus.ramstate = BUSY;
        end
        bus.dREN = 1'b1; bus.daddr = 32'h5FF;
        push(1'b0, 1'b1, 32'h11112222);
        push(1'b1, 1'b1, 32'h33334444);
        smp(); chk1("t3_idle4_ramREN", bus.ramREN, 1'b0);
        tick(); smp();
        chk1("t3_forced_ramREN", bus.ramREN, 1'b1);
        chk32("t3_forced_ramaddr", bus.ramaddr, 32'h400);
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h11112222;
        smp();
        tick(); bus.iREN = 1'b0; bus.ramstate = BUSY;
        smp();
        tick(); smp(); chk32("t3_dagain_ramaddr", bus.ramaddr, 32'h5FF);
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h33334444;
        smp();
        tick(); bus.dREN = 1'b0; bus.ramstate = FREE;
        smp();

        // dcache abort before ACCESS
        tick(); bus.dREN = 1'b1; bus.daddr = 32'h600; bus.ramstate = BUSY;
        smp();
        tick(); smp(); chk1("t4_gnt_ramREN", bus.ramREN, 1'b1);
        tick(); bus.dREN = 1'b0;
        smp(); chk1("t4_abort_ramREN", bus.ramREN, 1'b0); chk1("t4_abort_dwait", bus.dwait, 1'b1);
        tick(); smp(); chk1("t4_after_ramREN", bus.ramREN, 1'b0); chk1("t4_err", bus.err, 1'b0);

        // reset mid-DGRANT with iREN pending
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'h900; bus.dREN = 1'b1; bus.daddr = 32'h901; bus.ramstate = BUSY;
        smp();
        tick(); smp(); chk32("t7_dgnt_ramaddr", bus.ramaddr, 32'h901);
        tick(); RST = 1'b1;
        smp();
        tick(); RST = 1'b0; bus.dREN = 1'b0;
        smp(); chk_reset("t7_rst");
        push(1'b0, 1'b1, 32'h900D900D);
        tick(); smp();
        chk1("t7_igrant_ramREN", bus.ramREN, 1'b1);
        chk32("t7_igrant_ramaddr", bus.ramaddr, 32'h900);
        tick(); bus.ramstate = ACCESS; bus.ramload = 32'h900D900D;
        smp();
        tick(); bus.iREN = 1'b0; bus.ramstate = FREE;
        smp();

        // ERROR while granted
        tick(); bus.iREN = 1'b1; bus.iaddr = 32'hA00; bus.ramstate = BUSY;
        smp();
        tick(); smp(); chk1("t5_gnt_ramREN", bus.ramREN, 1'b1);
        tick(); bus.ramstate = ERROR;
        smp(); chk1("t5_err_iwait", bus.iwait, 1'b1); chk1("t5_err_not_yet", bus.err, 1'b0);
        tick(); bus.ramstate = BUSY;
        smp(); chk1("t5_err_set", bus.err, 1'b1); chk1("t5_idle_ramREN", bus.ramREN, 1'b0);
        tick(); smp(); chk1("t5_rearb_ramREN", bus.ramREN, 1'b1);
        tick(); bus.iREN = 1'b0;
        smp();
        tick(); smp(); chk1("t5_err_sticky", bus.err, 1'b1);
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        smp(); chk_reset("t5_rst");

        // timeout: BUSY for the whole grant
        tick(); bus.dWEN = 1'b1; bus.daddr = 32'hB00; bus.dstore = 32'h77; bus.ramstate = BUSY;
        smp(); chk1("t6_idle_ramWEN", bus.ramWEN, 1'b0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick(); smp();
            if (bus.ramWEN !== 1'b1) break;
            n++;
        end
        chk32("t6_grant_cycles", 32'(n), 32'd255);
        chk1("t6_timeout_err", bus.err, 1'b1);
        tick(); bus.dWEN = 1'b0; bus.ramstate = FREE;
        smp();

        tick(); smp();
        chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
